// File: rtl/seq_div_pkg.sv
// ============================================================================
// Module      : seq_div_pkg
// Description : Shared types and constants for the sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_if.sv
// ============================================================================
// Module      : seq_divider_if
// Description : Start/busy/done handshake and operand/result bundle of the divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_divider_if
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// ============================================================================
// Module      : div_step
// Description : Combinational single-bit restoring division step (MSB first).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_divisor_ext;
    // Partial remainder always stays below the divisor, so its MSB is zero here.
    logic           w_unused_msb;

    assign w_unused_msb  = rem_in[WIDTH];
    assign w_shifted     = {rem_in[WIDTH-1:0], bit_in};
    assign w_divisor_ext = {1'b0, divisor};

    always_comb begin
        q_bit   = 1'b0;
        rem_out = w_shifted;
        if (w_shifted >= w_divisor_ext) begin
            q_bit   = 1'b1;
            rem_out = w_shifted - w_divisor_ext;
        end
    end
endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module      : seq_divider
// Description : Sequential restoring unsigned divider, one quotient bit per clock.
//               Optional zero-divisor fast path: define SEQ_DIV_ZERO_FAST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic          clk,
    input  logic          reset_n,
    seq_divider_if.slave  bus
);
    localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] r_dividend_shift;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quot_work;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic [WIDTH:0]   w_rem_next;
    logic             w_qbit;
`ifdef SEQ_DIV_ZERO_FAST_EN
    logic             w_fast;
    logic             r_div_by_zero;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (r_rem),
        .bit_in  (r_dividend_shift[WIDTH-1]),
        .divisor (r_divisor),
        .rem_out (w_rem_next),
        .q_bit   (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // DONE accepts a new request exactly like IDLE so back-to-back runs lose no cycle.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
`ifdef SEQ_DIV_ZERO_FAST_EN
        w_fast   = 1'b0;
`endif
        case (r_state)
            IDLE, DONE: begin
                w_next = IDLE;
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
`ifdef SEQ_DIV_ZERO_FAST_EN
                    if (bus.divisor == '0) begin
                        w_fast = 1'b1;
                        w_next = DONE;
                    end
`endif
                end
            end
            RUN: begin
                if (r_count == LAST_STEP) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dividend_shift <= '0;
            r_divisor        <= '0;
            r_rem            <= '0;
            r_quot_work      <= '0;
            r_count          <= '0;
            r_quotient       <= '0;
            r_remainder      <= '0;
`ifdef SEQ_DIV_ZERO_FAST_EN
            r_div_by_zero    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_dividend_shift <= bus.dividend;
            r_divisor        <= bus.divisor;
            r_rem            <= '0;
            r_quot_work      <= '0;
            r_count          <= '0;
`ifdef SEQ_DIV_ZERO_FAST_EN
            if (w_fast) begin
                r_quotient    <= '1;
                r_remainder   <= bus.dividend;
                r_div_by_zero <= 1'b1;
            end
`endif
        end else if (r_state == RUN) begin
            r_dividend_shift <= {r_dividend_shift[WIDTH-2:0], 1'b0};
            r_rem            <= w_rem_next;
            r_quot_work      <= {r_quot_work[WIDTH-2:0], w_qbit};
            r_count          <= r_count + 1'b1;
            if (w_last) begin
                r_quotient    <= {r_quot_work[WIDTH-2:0], w_qbit};
                r_remainder   <= w_rem_next[WIDTH-1:0];
`ifdef SEQ_DIV_ZERO_FAST_EN
                r_div_by_zero <= 1'b0;
`endif
            end
        end
    end

    assign bus.busy      = (r_state == RUN);
    assign bus.done      = (r_state == DONE);
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
`ifdef SEQ_DIV_ZERO_FAST_EN
    assign bus.div_by_zero = r_div_by_zero;
`else
    assign bus.div_by_zero = 1'b0;
`endif
endmodule

`default_nettype wire
